// File: rtl/lsq_sched.sv
// lsq_sched: in-order load/store queue scheduler.
//
// Dispatched loads and stores are held in a circular FIFO. They are issued to a
// data memory strictly in dispatch order. The memory reads combinationally and
// writes on the clock edge. A store issues and retires in a single cycle. A load
// captures its read data in the cycle it issues, then holds the FSM in BCAST
// until its result is granted on the CDB. While a load waits for its grant, the
// FIFO keeps accepting entries until it is full.
//
// Optional build macro: LSQ_BYPASS_EN. When it is defined, a dispatch arriving
// at an empty queue in IDLE issues to memory in the same cycle and does not
// occupy a FIFO slot.
//
// Handshake: an entry transfers when disp_valid && disp_ready && !flush at the
// rising edge. disp_ready depends only on occupancy (q_count < DEPTH), never on
// disp_valid, and it does not rise on a same-cycle pop. A full queue therefore
// accepts nothing, even in a cycle where the head retires.
// cdb_req stays high with stable cdb_data/cdb_tag until the cycle in which
// cdb_gnt is seen. flush overrides cdb_gnt.

module lsq_sched #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic                     disp_ls,
   input  logic [31:0]              disp_addr,
   input  logic [31:0]              disp_data,
   input  logic [5:0]               disp_tag,
   input  logic                     flush,
   output logic                     mem_we,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_data_w,
   input  logic [31:0]              mem_data_r,
   output logic                     cdb_req,
   input  logic                     cdb_gnt,
   output logic [31:0]              cdb_data,
   output logic [5:0]               cdb_tag,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic                     dbg_state
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef enum logic {
      IDLE  = 1'b0,
      BCAST = 1'b1
   } state_t;

   state_t state, state_nx;

   // FIFO storage and pointers
   logic          ls_q   [DEPTH];
   logic [31:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [5:0]    tag_q  [DEPTH];
   logic [PW-1:0] head_ptr, tail_ptr;
   logic [PW:0]   count;

   // Result register for the load awaiting broadcast
   logic [31:0]   res_data;
   logic [5:0]    res_tag;

   // Issue-path signals for the access selected this cycle
   logic          push, pop, bypass;
   logic          issue, issue_ls;
   logic [31:0]   issue_addr, issue_data;
   logic [5:0]    issue_tag;
   logic          load_issue;

   assign disp_ready = (count < FULL_CNT);
   assign q_count    = count;
   assign dbg_state  = (state == BCAST);

   // Pick the access to issue this cycle. Only IDLE issues. flush and reset
   // suppress every access.
   always_comb begin
      pop        = 1'b0;
      bypass     = 1'b0;
      issue      = 1'b0;
      issue_ls   = 1'b0;
      issue_addr = 32'h0;
      issue_data = 32'h0;
      issue_tag  = 6'h0;
      if (rst_n && !flush && state == IDLE) begin
         if (count != '0) begin
            pop        = 1'b1;
            issue      = 1'b1;
            issue_ls   = ls_q[head_ptr];
            issue_addr = addr_q[head_ptr];
            issue_data = data_q[head_ptr];
            issue_tag  = tag_q[head_ptr];
         end
`ifdef LSQ_BYPASS_EN
         else if (disp_valid) begin
            bypass     = 1'b1;
            issue      = 1'b1;
            issue_ls   = disp_ls;
            issue_addr = disp_addr;
            issue_data = disp_data;
            issue_tag  = disp_tag;
         end
`endif
      end
   end

   // A bypassed dispatch is accepted but never enters the FIFO
   assign push       = disp_valid && disp_ready && !flush && !bypass;
   assign load_issue = issue && !issue_ls;

   // Memory port: drive address and data only when an access is issued
   always_comb begin
      mem_we     = 1'b0;
      mem_addr   = 32'h0;
      mem_data_w = 32'h0;
      if (issue) begin
         mem_addr = issue_addr;
         if (issue_ls) begin
            mem_we     = 1'b1;
            mem_data_w = issue_data;
         end
      end
   end

   // FIFO payload write at the tail. Occupancy tracking guards against stale reads.
   always_ff @(posedge clk) begin
      if (push) begin
         ls_q[tail_ptr]   <= disp_ls;
         addr_q[tail_ptr] <= disp_addr;
         data_q[tail_ptr] <= disp_data;
         tag_q[tail_ptr]  <= disp_tag;
      end
   end

   // Pointer and occupancy update. flush empties the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else if (flush) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (push) tail_ptr <= tail_ptr + PW'(1);
         if (pop)  head_ptr <= head_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Capture load data and tag in the cycle the load reads memory
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data <= 32'h0;
         res_tag  <= 6'h0;
      end else if (load_issue) begin
         res_data <= mem_data_r;
         res_tag  <= issue_tag;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // FSM next state and CDB outputs. BCAST holds the result until it is granted.
   always_comb begin
      state_nx = state;
      cdb_req  = 1'b0;
      cdb_data = 32'h0;
      cdb_tag  = 6'h0;
      case (state)
         IDLE: begin
            if (load_issue) state_nx = BCAST;
         end
         BCAST: begin
            cdb_req  = 1'b1;
            cdb_data = res_data;
            cdb_tag  = res_tag;
            if (flush || cdb_gnt) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsq_sched.sv
// tb_lsq_sched: directed test sequence for lsq_sched in its default build.
// Inputs change on the falling edge. Outputs are checked 1 time unit later,
// well away from the rising edge. The data memory is a small model inside this
// bench: combinational read, write on the clock edge.

module tb_lsq_sched;

   logic        clk;
   logic        rst_n;
   logic        disp_valid;
   logic        disp_ready;
   logic        disp_ls;
   logic [31:0] disp_addr;
   logic [31:0] disp_data;
   logic [5:0]  disp_tag;
   logic        flush;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_w;
   logic [31:0] mem_data_r;
   logic        cdb_req;
   logic        cdb_gnt;
   logic [31:0] cdb_data;
   logic [5:0]  cdb_tag;
   logic [2:0]  q_count;
   logic        dbg_state;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:255] = '{default: 32'h0};

   lsq_sched #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .disp_valid (disp_valid),
      .disp_ready (disp_ready),
      .disp_ls    (disp_ls),
      .disp_addr  (disp_addr),
      .disp_data  (disp_data),
      .disp_tag   (disp_tag),
      .flush      (flush),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_data_w (mem_data_w),
      .mem_data_r (mem_data_r),
      .cdb_req    (cdb_req),
      .cdb_gnt    (cdb_gnt),
      .cdb_data   (cdb_data),
      .cdb_tag    (cdb_tag),
      .q_count    (q_count),
      .dbg_state  (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model
   assign mem_data_r = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_data_w;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic disp(input logic ls, input logic [31:0] a, input logic [31:0] d, input logic [5:0] t);
      disp_valid = 1'b1;
      disp_ls    = ls;
      disp_addr  = a;
      disp_data  = d;
      disp_tag   = t;
   endtask

   task automatic idle_in();
      disp_valid = 1'b0;
      disp_ls    = 1'b0;
      disp_addr  = 32'h0;
      disp_data  = 32'h0;
      disp_tag   = 6'h0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; cdb_gnt = 1'b0;
      idle_in();

      // reset values
      tick(); #1;
      chk("rst_ready", disp_ready, 1);
      chk("rst_count", q_count, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_req", cdb_req, 0);
      chk("rst_cdata", cdb_data, 0);
      tick(); rst_n = 1'b1; #1;
      chk("idle_count", q_count, 0);

      // store 0x100 then load 0x100 tag 5
      tick(); disp(1'b1, 32'h100, 32'hDEADBEEF, 6'd0); #1;
      chk("st_noissue_we", mem_we, 0);
      chk("st_noissue_cnt", q_count, 0);
      tick(); disp(1'b0, 32'h100, 32'h0, 6'd5); #1;
      chk("st_we", mem_we, 1);
      chk("st_addr", mem_addr, 32'h100);
      chk("st_data", mem_data_w, 32'hDEADBEEF);
      chk("st_cnt", q_count, 1);
      tick(); idle_in(); #1;
      chk("ld_we", mem_we, 0);
      chk("ld_addr", mem_addr, 32'h100);
      chk("ld_wdata", mem_data_w, 0);
      chk("ld_req_pre", cdb_req, 0);
      tick(); cdb_gnt = 1'b1; #1;
      chk("bc_req", cdb_req, 1);
      chk("bc_data", cdb_data, 32'hDEADBEEF);
      chk("bc_tag", cdb_tag, 5);
      chk("bc_we", mem_we, 0);
      chk("bc_addr", mem_addr, 0);
      chk("bc_state", dbg_state, 1);
      tick(); cdb_gnt = 1'b0; #1;
      chk("bc_done_req", cdb_req, 0);
      chk("bc_done_tag", cdb_tag, 0);

      // four back-to-back stores drain one per cycle
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i < 4) disp(1'b1, 32'h200 + 32'(4*i), 32'(i+1), 6'd0);
         else       idle_in();
         #1;
         chk("str_ready", disp_ready, 1);
         if (i == 0) begin
            chk("str_cnt0", q_count, 0);
            chk("str_we0", mem_we, 0);
         end else begin
            chk("str_cnt", q_count, 1);
            chk("str_we", mem_we, 1);
            chk("str_addr", mem_addr, 32'h200 + 32'(4*(i-1)));
            chk("str_data", mem_data_w, 32'(i));
         end
      end
      tick(); #1;
      chk("str_drained_cnt", q_count, 0);
      chk("str_drained_we", mem_we, 0);

      // load stalls in BCAST while four stores fill the queue
      tick(); disp(1'b0, 32'h200, 32'h0, 6'd7); #1;
      chk("fill_ld_we", mem_we, 0);
      tick(); disp(1'b1, 32'h400, 32'h11, 6'd0); #1;
      chk("fill_ld_addr", mem_addr, 32'h200);
      chk("fill_ld_we1", mem_we, 0);
      tick(); disp(1'b1, 32'h404, 32'h22, 6'd0); #1;
      chk("fill_req", cdb_req, 1);
      chk("fill_cdata", cdb_data, 1);
      chk("fill_ctag", cdb_tag, 7);
      chk("fill_cnt1", q_count, 1);
      tick(); disp(1'b1, 32'h408, 32'h33, 6'd0); #1;
      chk("fill_cnt2", q_count, 2);
      tick(); disp(1'b1, 32'h40C, 32'h44, 6'd0); #1;
      chk("fill_cnt3", q_count, 3);
      chk("fill_ready3", disp_ready, 1);
      tick(); disp(1'b1, 32'h410, 32'h55, 6'd0); #1;
      chk("fill_cnt4", q_count, 4);
      chk("fill_ready4", disp_ready, 0);
      chk("fill_we4", mem_we, 0);
      tick(); #1;
      chk("full_hold_cnt", q_count, 4);
      chk("full_hold_ready", disp_ready, 0);

      // flush with a full queue, grant raised in the same cycle
      tick(); idle_in(); flush = 1'b1; cdb_gnt = 1'b1; #1;
      chk("fl4_we", mem_we, 0);
      chk("fl4_addr", mem_addr, 0);
      tick(); flush = 1'b0; cdb_gnt = 1'b0; #1;
      chk("fl4_req", cdb_req, 0);
      chk("fl4_cnt", q_count, 0);
      chk("fl4_ready", disp_ready, 1);
      chk("fl4_mem", mem[0], 0);

      // load tag 9 waits five cycles for its grant
      tick(); disp(1'b0, 32'h100, 32'h0, 6'd9); #1;
      chk("g9_we", mem_we, 0);
      tick(); idle_in(); #1;
      chk("g9_addr", mem_addr, 32'h100);
      for (int k = 0; k < 5; k++) begin
         tick(); #1;
         chk("g9_req", cdb_req, 1);
         chk("g9_tag", cdb_tag, 9);
         chk("g9_data", cdb_data, 32'hDEADBEEF);
      end
      tick(); cdb_gnt = 1'b1; #1;
      chk("g9_gnt_req", cdb_req, 1);
      chk("g9_gnt_tag", cdb_tag, 9);
      tick(); cdb_gnt = 1'b0; #1;
      chk("g9_rel_req", cdb_req, 0);
      chk("g9_rel_state", dbg_state, 0);

      // flush in BCAST with three entries queued
      tick(); disp(1'b0, 32'h204, 32'h0, 6'd3); #1;
      tick(); disp(1'b1, 32'h500, 32'h66, 6'd0); #1;
      chk("f3_ld_addr", mem_addr, 32'h204);
      tick(); disp(1'b1, 32'h504, 32'h77, 6'd0); #1;
      chk("f3_cdata", cdb_data, 2);
      chk("f3_ctag", cdb_tag, 3);
      chk("f3_cnt1", q_count, 1);
      tick(); disp(1'b1, 32'h508, 32'h88, 6'd0); #1;
      chk("f3_cnt2", q_count, 2);
      tick(); idle_in(); flush = 1'b1; #1;
      chk("f3_cnt3", q_count, 3);
      chk("f3_fl_we", mem_we, 0);
      chk("f3_fl_req", cdb_req, 1);
      tick(); flush = 1'b0; #1;
      chk("f3_req", cdb_req, 0);
      chk("f3_cnt", q_count, 0);
      chk("f3_we", mem_we, 0);
      tick(); #1;
      chk("f3_we2", mem_we, 0);

      // reset with two stores pending behind a stalled load
      tick(); disp(1'b0, 32'h300, 32'h0, 6'd1); #1;
      tick(); disp(1'b1, 32'h300, 32'hAA, 6'd0); #1;
      tick(); disp(1'b1, 32'h304, 32'hBB, 6'd0); #1;
      chk("r_req", cdb_req, 1);
      tick(); idle_in(); #1;
      chk("r_cnt2", q_count, 2);
      rst_n = 1'b0; #1;
      chk("r_cnt0", q_count, 0);
      chk("r_req0", cdb_req, 0);
      chk("r_we0", mem_we, 0);
      chk("r_ready", disp_ready, 1);
      chk("r_cdata", cdb_data, 0);
      chk("r_ctag", cdb_tag, 0);
      chk("r_addr", mem_addr, 0);
      tick(); #1;
      chk("r_hold_we", mem_we, 0);
      tick(); rst_n = 1'b1; #1;
      chk("r_rel_cnt", q_count, 0);
      chk("r_rel_we", mem_we, 0);
      for (int k = 0; k < 3; k++) begin
         tick(); #1;
         chk("r_post_we", mem_we, 0);
         chk("r_post_req", cdb_req, 0);
      end
      chk("r_mem0", mem[8'hC0], 0);
      chk("r_mem1", mem[8'hC1], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
